h_dec_err_monitor: RTL and testbench
====================================

Name: h_dec_err_monitor

Overview:
Downstream stage of h_decoder_11_7 that consumes its decoded word, syndrome and correctable/detected error flags per codeword.
- Buffers decoded data behind a valid/ready handshake.
- Optionally discards uncorrectable words.
- Keeps saturating error statistics.
- Raises a sticky alarm when detected (uncorrectable) errors in a sliding block of words reach a threshold.

Parameters:
- DEPTH, 2, output buffer entries (power of 2, >=2).
- CNT_W, 16, width of error statistics counters.
- WINDOW, 64, accepted words per evaluation window (>=2).
- THRESH, 4, detected-error count per window that trips the alarm (1..WINDOW).
- DROP_UNCORR, 1, 1 = words with i_ErrorD are counted but not forwarded.

Ports:
- i_Clk  in  1  clock, all state on rising edge.
- i_Rst  in  1  synchronous, active-high reset.
- i_Valid  in  1  decoder output valid.
- o_Ready  out  1  block can accept a word this cycle.
- i_DecodWord  in  7  decoded data word.
- i_Syndrome  in  5  decoder syndrome.
- i_ErrorC  in  1  single error corrected.
- i_ErrorD  in  1  uncorrectable error detected.
- o_Valid  out  1  output word valid.
- i_Ready  in  1  downstream ready.
- o_Data  out  7  buffered decoded word.
- o_DataErrC  out  1  o_Data was corrected.
- o_CorrCnt  out  CNT_W  corrected-error count, saturating.
- o_DetCnt  out  CNT_W  detected-error count, saturating.
- i_CntClr  in  1  clear both counters.
- o_Alarm  out  1  sticky window alarm.
- i_AlarmClr  in  1  clear alarm, restart window.

Behaviour:
- Reset (i_Rst high at edge): buffer empty, o_Valid=0, o_Ready=1 (registered), o_Data=0, o_DataErrC=0, counters=0, window counters=0, FSM=COUNT, o_Alarm=0. Reset mid-transfer discards buffered words.
- Accept = i_Valid && o_Ready. o_Ready = buffer not full, registered; it does not depend combinationally on i_Ready.
- Output handshake: o_Data/o_DataErrC hold stable while o_Valid && !i_Ready. Pop = o_Valid && i_Ready.
- Forwarded word enters the buffer at accept; o_Valid rises the next cycle. Latency is 1 cycle when empty.
- Full buffer with simultaneous push and pop: both succeed, count unchanged, FIFO order kept.
- Full buffer: o_Ready=0. Throughput is 1 word/cycle when downstream is always ready.
- Drop rule: if DROP_UNCORR=1 and i_ErrorD, the word is accepted (counted) but not pushed. With DROP_UNCORR=0, all accepted words are pushed.
- Counters: on accept, i_ErrorC increments o_CorrCnt; i_ErrorD increments o_DetCnt. Both hold at 2^CNT_W-1. If i_ErrorC and i_ErrorD are both set, treat the word as ErrorD only.
- i_CntClr in the same cycle as an increment: clear wins, result is 0.
- Window FSM, states COUNT and ALARM:
  - COUNT: wcnt counts accepted words (0..WINDOW-1); dcnt counts accepted ErrorD words (saturates at THRESH).
  - On the accept that makes dcnt reach THRESH: move to ALARM, o_Alarm=1 next cycle.
  - On the accept with wcnt=WINDOW-1 and no trip: wcnt and dcnt reset to 0 and stay in COUNT. The wrap-around word's own ErrorD is included in the old window.
  - ALARM: o_Alarm=1 and the window counters frozen; statistics counters keep running.
  - i_AlarmClr returns to COUNT with wcnt=dcnt=0. In COUNT, i_AlarmClr only restarts the window.
  - i_AlarmClr in the same cycle as a tripping accept: clear wins, that word is not counted in the new window.
- i_Syndrome is used only by the optional feature.

Optional Feature:
- Macro H_SYND_LOG_EN.
- When defined:
  - Adds an 8-entry syndrome log FIFO, written on each accepted word with i_ErrorC or i_ErrorD. Entry = {i_ErrorD, i_Syndrome}, 6 bits.
  - Adds ports i_LogRd (in 1), o_LogData (out 6, head entry), o_LogEmpty (out 1), o_LogOvf (out 1).
  - o_LogOvf is sticky, set when a write hits a full log. That write is dropped. o_LogOvf is cleared by i_CntClr.
  - A read on an empty log is ignored. Simultaneous read and write on a full log succeeds.
  - Reset empties the log and clears o_LogOvf.
- When undefined: no log ports or logic; i_Syndrome is unused.

Decomposition:
- Package h_code_pkg: constants DATA_W=7, SYND_W=5, CW_W=12; log entry struct type, fields err_d and synd; FSM state enum (COUNT, ALARM).
- Sub-module h_sync_fifo (parameterised width/depth, registered full/empty). It is used for the output buffer and the syndrome log.

Test Plan:
- Reset, then 4 clean words 0x00,0x15,0x2A,0x7F with i_Ready=1 -> same words out in order, 1-cycle latency, counters 0, o_Alarm=0.
- i_Ready held 0, 3 words offered -> first 2 accepted, o_Ready=0 on the 3rd; release i_Ready -> 0x01,0x02 then 0x03 delivered, none lost.
- 5 words with i_ErrorC=1, 2 with i_ErrorD=1, DROP_UNCORR=1 -> 5 words forwarded with o_DataErrC=1, o_CorrCnt=5, o_DetCnt=2.
- THRESH=4, WINDOW=64: 4 ErrorD words within the first 10 -> o_Alarm=1 the cycle after the 4th. i_AlarmClr -> 0. Then 3 ErrorD at the end of one window and 1 at the start of the next -> no alarm.
- CNT_W=4: 20 ErrorC words -> o_CorrCnt saturates at 15. i_CntClr coincident with an ErrorC accept -> 0.
- H_SYND_LOG_EN: 9 error words, no reads -> 8 entries logged, o_LogOvf=1. Read all -> first entry {0,5'b00011} returned, o_LogEmpty=1 after the 8th read.

Source files
------------

// File: rtl/h_code_pkg.sv
// Shared constants and types for the Hamming(11,7) decoder back-end blocks.
package h_code_pkg;

    localparam int DATA_W    = 7;
    localparam int SYND_W    = 5;
    localparam int CW_W      = 12;
    localparam int LOG_DEPTH = 8;

    // One syndrome log record: was the word uncorrectable, and its syndrome.
    typedef struct packed {
        logic              err_d;
        logic [SYND_W-1:0] synd;
    } log_entry_t;

    // Window monitor states.
    typedef enum logic [0:0] {
        COUNT = 1'b0,
        ALARM = 1'b1
    } win_state_t;

endpackage

// File: rtl/h_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags.
// A write into a full FIFO succeeds only when a read happens in the same
// cycle; a read from an empty FIFO is ignored. rd_data shows the head entry.
module h_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wptr;
    logic [AW-1:0]               rptr;
    logic [AW:0]                 cnt;
    logic [AW:0]                 cnt_nxt;
    logic                        wr_ok;
    logic                        rd_ok;

    assign wr_ok   = wr_en && (!full || rd_en);
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rptr];

    // Occupancy after this cycle's read/write.
    always_comb begin
        cnt_nxt = cnt;
        if (wr_ok && !rd_ok)
            cnt_nxt = cnt + (AW+1)'(1);
        else if (rd_ok && !wr_ok)
            cnt_nxt = cnt - (AW+1)'(1);
    end

    // Storage, pointers and flags; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (wr_ok) begin
                mem[wptr] <= wr_data;
                wptr      <= wptr + AW'(1);
            end
            if (rd_ok)
                rptr <= rptr + AW'(1);
            cnt   <= cnt_nxt;
            full  <= (cnt_nxt == (AW+1)'(DEPTH));
            empty <= (cnt_nxt == '0);
        end
    end

endmodule

// File: rtl/h_dec_err_monitor.sv
// Error monitor behind the Hamming(11,7) decoder: buffers decoded words,
// optionally drops uncorrectable ones, keeps saturating error counts and
// raises a sticky alarm when detected errors in a window reach THRESH.
// Optional syndrome log enabled by defining H_SYND_LOG_EN.
module h_dec_err_monitor
    import h_code_pkg::*;
#(
    parameter int DEPTH       = 2,
    parameter int CNT_W       = 16,
    parameter int WINDOW      = 64,
    parameter int THRESH      = 4,
    parameter int DROP_UNCORR = 1
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Valid,
    output logic              o_Ready,
    input  logic [DATA_W-1:0] i_DecodWord,
    input  logic [SYND_W-1:0] i_Syndrome,
    input  logic              i_ErrorC,
    input  logic              i_ErrorD,
    output logic              o_Valid,
    input  logic              i_Ready,
    output logic [DATA_W-1:0] o_Data,
    output logic              o_DataErrC,
    output logic [CNT_W-1:0]  o_CorrCnt,
    output logic [CNT_W-1:0]  o_DetCnt,
    input  logic              i_CntClr,
`ifdef H_SYND_LOG_EN
    input  logic              i_LogRd,
    output logic [5:0]        o_LogData,
    output logic              o_LogEmpty,
    output logic              o_LogOvf,
`endif
    input  logic              i_AlarmClr,
    output logic              o_Alarm
);

    localparam int WC_W = $clog2(WINDOW);
    localparam int DC_W = $clog2(THRESH + 1);

    logic              accept;
    logic              err_c;
    logic              push;
    logic              buf_full;
    logic              buf_empty;
    logic [DATA_W:0]   buf_out;

    win_state_t        state, state_nxt;
    logic [WC_W-1:0]   wcnt, wcnt_nxt;
    logic [DC_W-1:0]   dcnt, dcnt_nxt;

    // A word flagged both ways is treated as uncorrectable only.
    assign accept = i_Valid && o_Ready;
    assign err_c  = i_ErrorC && !i_ErrorD;
    assign push   = accept && !((DROP_UNCORR != 0) && i_ErrorD);

    h_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk     (i_Clk),
        .rst     (i_Rst),
        .wr_en   (push),
        .wr_data ({err_c, i_DecodWord}),
        .rd_en   (i_Ready),
        .rd_data (buf_out),
        .full    (buf_full),
        .empty   (buf_empty)
    );

    // Ready comes straight from the registered full flag, never from i_Ready.
    assign o_Ready                = !buf_full;
    assign o_Valid                = !buf_empty;
    assign {o_DataErrC, o_Data}   = buf_out;

    // Saturating statistics; a clear overrides a same-cycle increment.
    always_ff @(posedge i_Clk) begin
        if (i_Rst || i_CntClr) begin
            o_CorrCnt <= '0;
            o_DetCnt  <= '0;
        end else begin
            if (accept && err_c && (o_CorrCnt != '1))
                o_CorrCnt <= o_CorrCnt + CNT_W'(1);
            if (accept && i_ErrorD && (o_DetCnt != '1))
                o_DetCnt <= o_DetCnt + CNT_W'(1);
        end
    end

    // Window state register.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state <= COUNT;
            wcnt  <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            dcnt  <= dcnt_nxt;
        end
    end

    // Window next-state: trip on THRESH detected errors, else restart each WINDOW words.
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        dcnt_nxt  = dcnt;
        case (state)
            COUNT: begin
                if (i_AlarmClr) begin
                    wcnt_nxt = '0;
                    dcnt_nxt = '0;
                end else if (accept) begin
                    if (i_ErrorD && (dcnt == DC_W'(THRESH - 1))) begin
                        state_nxt = ALARM;
                        dcnt_nxt  = DC_W'(THRESH);
                    end else if (wcnt == WC_W'(WINDOW - 1)) begin
                        wcnt_nxt = '0;
                        dcnt_nxt = '0;
                    end else begin
                        wcnt_nxt = wcnt + WC_W'(1);
                        dcnt_nxt = dcnt + DC_W'(i_ErrorD);
                    end
                end
            end
            ALARM: begin
                if (i_AlarmClr) begin
                    state_nxt = COUNT;
                    wcnt_nxt  = '0;
                    dcnt_nxt  = '0;
                end
            end
            default: begin
                state_nxt = COUNT;
                wcnt_nxt  = '0;
                dcnt_nxt  = '0;
            end
        endcase
    end

    assign o_Alarm = (state == ALARM);

`ifdef H_SYND_LOG_EN
    log_entry_t log_in;
    log_entry_t log_out;
    logic       log_wr;
    logic       log_full;

    assign log_in = {i_ErrorD, i_Syndrome};
    assign log_wr = accept && (i_ErrorC || i_ErrorD);

    h_sync_fifo #(
        .WIDTH ($bits(log_entry_t)),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk     (i_Clk),
        .rst     (i_Rst),
        .wr_en   (log_wr),
        .wr_data (log_in),
        .rd_en   (i_LogRd),
        .rd_data (log_out),
        .full    (log_full),
        .empty   (o_LogEmpty)
    );

    assign o_LogData = log_out;

    // Sticky overflow: a write lost to a full log with no same-cycle read.
    always_ff @(posedge i_Clk) begin
        if (i_Rst || i_CntClr)
            o_LogOvf <= 1'b0;
        else if (log_wr && log_full && !i_LogRd)
            o_LogOvf <= 1'b1;
    end
`else
    logic unused_synd;
    assign unused_synd = ^i_Syndrome;
`endif

endmodule

// File: tb/tb_h_dec_err_monitor.sv
// Directed plus random bench for h_dec_err_monitor against a queue-based model.
module tb_h_dec_err_monitor;

    localparam int DEPTH  = 2;
    localparam int CNT_W  = 4;
    localparam int WINDOW = 64;
    localparam int THRESH = 4;
    localparam int DROP   = 1;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic             i_Clk, i_Rst, i_Valid, i_ErrorC, i_ErrorD, i_Ready;
    logic             i_CntClr, i_AlarmClr;
    logic [6:0]       i_DecodWord;
    logic [4:0]       i_Syndrome;
    logic             o_Ready, o_Valid, o_DataErrC, o_Alarm;
    logic [6:0]       o_Data;
    logic [CNT_W-1:0] o_CorrCnt, o_DetCnt;
`ifdef H_SYND_LOG_EN
    logic             i_LogRd, o_LogEmpty, o_LogOvf;
    logic [5:0]       o_LogData;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] mq[$];
    int         win_q[$];
    int         m_corr, m_det;
    bit         m_alarm, last_acc;

    h_dec_err_monitor #(
        .DEPTH(DEPTH), .CNT_W(CNT_W), .WINDOW(WINDOW),
        .THRESH(THRESH), .DROP_UNCORR(DROP)
    ) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Valid(i_Valid), .o_Ready(o_Ready),
        .i_DecodWord(i_DecodWord), .i_Syndrome(i_Syndrome),
        .i_ErrorC(i_ErrorC), .i_ErrorD(i_ErrorD), .o_Valid(o_Valid),
        .i_Ready(i_Ready), .o_Data(o_Data), .o_DataErrC(o_DataErrC),
        .o_CorrCnt(o_CorrCnt), .o_DetCnt(o_DetCnt), .i_CntClr(i_CntClr),
`ifdef H_SYND_LOG_EN
        .i_LogRd(i_LogRd), .o_LogData(o_LogData), .o_LogEmpty(o_LogEmpty),
        .o_LogOvf(o_LogOvf),
`endif
        .i_AlarmClr(i_AlarmClr), .o_Alarm(o_Alarm)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, compare against model, advance model past posedge.
    task automatic cycle(input bit v, input logic [6:0] d, input bit ec, input bit ed,
                         input bit rdy, input bit cclr, input bit aclr, input logic [4:0] syn);
        bit m_rdy, acc, pop, push;
        i_Valid = v; i_DecodWord = d; i_ErrorC = ec; i_ErrorD = ed;
        i_Ready = rdy; i_CntClr = cclr; i_AlarmClr = aclr; i_Syndrome = syn;
        m_rdy = (mq.size() < DEPTH);
        check("o_Ready", o_Ready, m_rdy);
        check("o_Valid", o_Valid, mq.size() > 0);
        if (mq.size() > 0) begin
            check("o_Data", o_Data, mq[0][6:0]);
            check("o_DataErrC", o_DataErrC, mq[0][7]);
        end
        check("o_CorrCnt", o_CorrCnt, m_corr);
        check("o_DetCnt", o_DetCnt, m_det);
        check("o_Alarm", o_Alarm, m_alarm);
        acc  = v && m_rdy;
        pop  = rdy && (mq.size() > 0);
        push = acc && !(DROP != 0 && ed);
        @(posedge i_Clk);
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back({ec && !ed, d});
        if (cclr) begin
            m_corr = 0; m_det = 0;
        end else if (acc) begin
            if (ed)      m_det  = (m_det  < MAXC) ? m_det + 1  : MAXC;
            else if (ec) m_corr = (m_corr < MAXC) ? m_corr + 1 : MAXC;
        end
        if (aclr) begin
            m_alarm = 0; win_q.delete();
        end else if (!m_alarm && acc) begin
            win_q.push_back(int'(ed));
            if (win_q.sum() >= THRESH) m_alarm = 1;
            else if (win_q.size() == WINDOW) win_q.delete();
        end
        last_acc = acc;
        @(negedge i_Clk);
    endtask

    // Hold a word on the input until it is accepted (bounded).
    task automatic send(input logic [6:0] d, input bit ec, input bit ed, input bit rdy,
                        input logic [4:0] syn);
        int n = 0;
        do begin
            cycle(1'b1, d, ec, ed, rdy, 1'b0, 1'b0, syn);
            n++;
        end while (!last_acc && n < 20);
        check("send_accept", last_acc, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 7'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'h0);
    endtask

    task automatic do_reset();
        i_Rst = 1'b1; i_Valid = 1'b0; i_Ready = 1'b0; i_CntClr = 1'b0; i_AlarmClr = 1'b0;
        i_ErrorC = 1'b0; i_ErrorD = 1'b0; i_DecodWord = 7'h0; i_Syndrome = 5'h0;
        @(posedge i_Clk); @(posedge i_Clk); @(negedge i_Clk);
        i_Rst = 1'b0;
        mq.delete(); win_q.delete();
        m_corr = 0; m_det = 0; m_alarm = 0;
        check("rst_o_Valid", o_Valid, 0);
        check("rst_o_Ready", o_Ready, 1);
        check("rst_o_Data", o_Data, 0);
        check("rst_o_DataErrC", o_DataErrC, 0);
        check("rst_o_CorrCnt", o_CorrCnt, 0);
        check("rst_o_DetCnt", o_DetCnt, 0);
        check("rst_o_Alarm", o_Alarm, 0);
    endtask

    logic [6:0] clean_words [4];

    initial begin
`ifdef H_SYND_LOG_EN
        i_LogRd = 1'b0;
`endif
        clean_words = '{7'h00, 7'h15, 7'h2A, 7'h7F};

        // Clean words, downstream always ready.
        do_reset();
        foreach (clean_words[i]) send(clean_words[i], 1'b0, 1'b0, 1'b1, 5'h0);
        idle(3);

        // Back-pressure: two fit, the third waits for space.
        send(7'h01, 1'b0, 1'b0, 1'b0, 5'h0);
        send(7'h02, 1'b0, 1'b0, 1'b0, 5'h0);
        cycle(1'b1, 7'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h0);
        cycle(1'b1, 7'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h0);
        send(7'h03, 1'b0, 1'b0, 1'b1, 5'h0);
        idle(4);

        // Corrected words forwarded, uncorrectable ones dropped but counted.
        for (int i = 0; i < 7; i++) send(7'(7'h10 + i), i < 5, i >= 5, 1'b1, 5'h0);
        idle(3);
        check("corr_cnt_5", o_CorrCnt, 5);
        check("det_cnt_2", o_DetCnt, 2);

        // Alarm trip inside one window, then a split burst that must not trip.
        do_reset();
        for (int i = 0; i < 10; i++) send(7'(i), 1'b0, (i % 2 == 1) && i < 8, 1'b1, 5'h0);
        check("alarm_set", o_Alarm, 1);
        cycle(1'b0, 7'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'h0);
        check("alarm_clr", o_Alarm, 0);
        for (int i = 0; i <= WINDOW; i++) send(7'(i), 1'b0, i >= WINDOW - 3, 1'b1, 5'h0);
        idle(2);
        check("alarm_split_window", o_Alarm, 0);

        // Counter saturation and clear-beats-increment.
        do_reset();
        for (int i = 0; i < 20; i++) send(7'(i), 1'b1, 1'b0, 1'b1, 5'h0);
        idle(2);
        check("corr_sat", o_CorrCnt, 15);
        cycle(1'b1, 7'h55, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'h0);
        check("cnt_clr_wins", o_CorrCnt, 0);
        idle(3);

`ifdef H_SYND_LOG_EN
        // Syndrome log overflow and read-back.
        do_reset();
        for (int i = 0; i < 9; i++) send(7'(i), 1'b1, 1'b0, 1'b1, 5'(i + 3));
        idle(2);
        check("log_ovf", o_LogOvf, 1);
        check("log_not_empty", o_LogEmpty, 0);
        for (int i = 0; i < 8; i++) begin
            check("log_data", o_LogData, 6'(i + 3));
            i_LogRd = 1'b1;
            idle(1);
            i_LogRd = 1'b0;
        end
        check("log_empty", o_LogEmpty, 1);
`endif

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 700; i++)
            cycle($urandom_range(0, 3) != 0, 7'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 79) == 0, $urandom_range(0, 49) == 0, 5'($urandom));
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
